// File: rtl/sap_acc_pkg.sv
// Shared types and constants for the accumulator bank and its shift step.
package sap_acc_pkg;

    typedef enum logic {IDLE, SHIFT} acc_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/acc_shift_step.sv
// Combinational one-bit shift or rotate of a WIDTH-bit word.
module acc_shift_step
    import sap_acc_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_dir,
    input  logic             i_rot,
    output logic [WIDTH-1:0] o_data
);

    logic w_fill_lsb;
    logic w_fill_msb;

    // With i_rot tied low the wrapped bit folds away to a plain zero fill.
    assign w_fill_lsb = i_rot & i_data[WIDTH-1];
    assign w_fill_msb = i_rot & i_data[0];

    always_comb begin
        o_data = i_data;
        if (i_dir == DIR_LEFT) begin
            o_data = {i_data[WIDTH-2:0], w_fill_lsb};
        end else begin
            o_data = {w_fill_msb, i_data[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/accumulator_bank.sv
// NREG x WIDTH register bank with a tri-state W-bus output, reg 0 flags and a serial shift engine.
// Define SAP_ACC_ROTATE_EN to add the rot port and rotate support.
module accumulator_bank
    import sap_acc_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREG  = 4,
    localparam int unsigned SEL_W = $clog2(NREG),
    localparam int unsigned AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             La_bar,
    input  logic             Ea,
    input  logic [SEL_W-1:0] sel,
    input  logic             Sh,
    input  logic             dir,
    input  logic [AMT_W-1:0] shamt,
`ifdef SAP_ACC_ROTATE_EN
    input  logic             rot,
`endif
    input  logic [WIDTH-1:0] data_in,
    output tri   [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] adder_sub_out,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             neg
);

    logic [WIDTH-1:0] r_regs [NREG];
    acc_state_t       r_state;
    acc_state_t       w_state_next;
    logic [SEL_W-1:0] r_tsel;
    logic             r_tdir;
    logic             w_trot;
    logic [AMT_W-1:0] r_count;
    logic             r_done;

    logic [AMT_W-1:0] w_amt;
    logic             w_start;
    logic             w_nop_done;
    logic             w_last_step;
    logic             w_load_blocked;
    logic [WIDTH-1:0] w_shift_src;
    logic [WIDTH-1:0] w_shift_res;

    assign w_amt = (shamt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : shamt;

`ifdef SAP_ACC_ROTATE_EN
    logic r_trot;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_trot <= 1'b0;
        end else if (w_start) begin
            r_trot <= rot;
        end
    end

    assign w_trot = r_trot;
`else
    assign w_trot = 1'b0;
`endif

    // Next state and handshake strobes; a load request in IDLE always beats Sh.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_nop_done   = 1'b0;
        w_last_step  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (Sh && La_bar) begin
                    if (w_amt == '0) begin
                        w_nop_done = 1'b1;
                    end else begin
                        w_start      = 1'b1;
                        w_state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (r_count == AMT_W'(1)) begin
                    w_last_step  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_tsel  <= '0;
            r_tdir  <= DIR_LEFT;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_nop_done | w_last_step;
            if (w_start) begin
                r_tsel  <= sel;
                r_tdir  <= dir;
                r_count <= w_amt;
            end else if (r_state == SHIFT) begin
                r_count <= r_count - AMT_W'(1);
            end
        end
    end

    assign w_shift_src = r_regs[r_tsel];

    acc_shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .i_data (w_shift_src),
        .i_dir  (r_tdir),
        .i_rot  (w_trot),
        .o_data (w_shift_res)
    );

    // The register under shift owns its input until the shift completes.
    assign w_load_blocked = (r_state == SHIFT) && (sel == r_tsel);

    always_ff @(posedge CLK) begin
        if (CLR) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (!La_bar && !w_load_blocked && (sel == SEL_W'(i))) begin
                    r_regs[i] <= data_in;
                end else if ((r_state == SHIFT) && (r_tsel == SEL_W'(i))) begin
                    r_regs[i] <= w_shift_res;
                end
            end
        end
    end

    assign data_out      = Ea ? r_regs[sel] : {WIDTH{1'bz}};
    assign adder_sub_out = r_regs[0];
    assign zero          = (r_regs[0] == '0);
    assign neg           = r_regs[0][WIDTH-1];
    assign busy          = (r_state == SHIFT);
    assign done          = r_done;

endmodule

// File: tb/tb_accumulator_bank.sv
// Self-checking bench for accumulator_bank (WIDTH=8, NREG=4): directed table, hand sequences,
// then randomized traffic against a behavioural model.
module tb_accumulator_bank;

`ifdef SAP_ACC_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic       CLK;
    logic       CLR;
    logic       La_bar;
    logic       Ea;
    logic [1:0] sel;
    logic       Sh;
    logic       dir;
    logic [3:0] shamt;
    logic       rot;
    logic [7:0] data_in;
    tri   [7:0] data_out;
    logic [7:0] adder_sub_out;
    logic       busy;
    logic       done;
    logic       zero;
    logic       neg;

    int n_pass  = 0;
    int n_total = 0;

    accumulator_bank #(
        .WIDTH (8),
        .NREG  (4)
    ) dut (
        .CLK           (CLK),
        .CLR           (CLR),
        .La_bar        (La_bar),
        .Ea            (Ea),
        .sel           (sel),
        .Sh            (Sh),
        .dir           (dir),
        .shamt         (shamt),
`ifdef SAP_ACC_ROTATE_EN
        .rot           (rot),
`endif
        .data_in       (data_in),
        .data_out      (data_out),
        .adder_sub_out (adder_sub_out),
        .busy          (busy),
        .done          (done),
        .zero          (zero),
        .neg           (neg)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       clr;
        logic       la_n;
        logic       sh;
        logic [1:0] sel;
        logic       dir;
        logic [3:0] amt;
        logic       rot;
        logic [7:0] din;
        logic       ea;
        logic [7:0] e_acc;
        logic       e_busy;
        logic       e_done;
        logic [7:0] e_dout;
    } vec_t;

    vec_t vecs[$];

    function automatic void row(input logic clr, la_n, sh, input logic [1:0] s, input logic d,
                                input logic [3:0] a, input logic r, input logic [7:0] din,
                                input logic ea, input logic [7:0] e_acc, input logic e_busy,
                                input logic e_done, input logic [7:0] e_dout);
        vec_t v;
        v.clr = clr; v.la_n = la_n; v.sh = sh; v.sel = s; v.dir = d; v.amt = a; v.rot = r;
        v.din = din; v.ea = ea; v.e_acc = e_acc; v.e_busy = e_busy; v.e_done = e_done;
        v.e_dout = e_dout;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    endtask

    task automatic drive(input logic clr, la_n, sh, input logic [1:0] s, input logic d,
                         input logic [3:0] a, input logic r, input logic [7:0] din,
                         input logic ea);
        CLR = clr; La_bar = la_n; Sh = sh; sel = s; dir = d; shamt = a; rot = r;
        data_in = din; Ea = ea;
    endtask

    task automatic check_outs(input string tag, input logic [7:0] e_acc, input logic e_busy,
                              input logic e_done, input logic ea_chk, input logic [7:0] e_dout);
        chk({tag, " acc"}, adder_sub_out, e_acc);
        chk({tag, " busy"}, {7'b0, busy}, {7'b0, e_busy});
        chk({tag, " done"}, {7'b0, done}, {7'b0, e_done});
        chk({tag, " zero"}, {7'b0, zero}, {7'b0, (e_acc == 8'h00)});
        chk({tag, " neg"}, {7'b0, neg}, {7'b0, e_acc[7]});
        if (ea_chk) chk({tag, " dout"}, data_out, e_dout);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Behavioural model: a shift is tracked as (original value, steps taken) and the
    // register content is recomputed arithmetically from those.
    logic [7:0] m_regs [4];
    bit         m_busy;
    bit         m_done;
    bit         m_tdir;
    bit         m_trot;
    int         m_tsel;
    int         m_k;
    int         m_j;
    logic [7:0] m_orig;

    function automatic logic [7:0] shf(input logic [7:0] v, input bit d, input bit r, input int n);
        int unsigned x;
        int unsigned y;
        x = v;
        if (!d) y = (x << n) | (r ? (x >> (8 - n)) : 0);
        else    y = (x >> n) | (r ? (x << (8 - n)) : 0);
        return y[7:0];
    endfunction

    task automatic model_step();
        bit nd;
        int amt;
        nd = 1'b0;
        if (CLR) begin
            for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_j++;
            m_regs[m_tsel] = shf(m_orig, m_tdir, m_trot, m_j);
            if (!La_bar && (int'(sel) != m_tsel)) m_regs[sel] = data_in;
            if (m_j == m_k) begin
                m_busy = 1'b0;
                nd     = 1'b1;
            end
        end else if (!La_bar) begin
            m_regs[sel] = data_in;
        end else if (Sh) begin
            amt = (int'(shamt) > 8) ? 8 : int'(shamt);
            if (amt == 0) begin
                nd = 1'b1;
            end else begin
                m_busy = 1'b1;
                m_tsel = int'(sel);
                m_tdir = dir;
                m_trot = rot & ROT_EN;
                m_orig = m_regs[sel];
                m_k    = amt;
                m_j    = 0;
            end
        end
        m_done = nd;
    endtask

    initial begin
        logic [7:0] e;
        drive(1, 1, 0, 0, 0, 0, 0, 8'h00, 0);

        // Reset, load, read
        row(1, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);
        row(0, 0, 0, 2, 0, 0, 0, 8'hA5, 1, 8'h00, 0, 0, 8'hA5);
        row(0, 1, 0, 2, 0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 8'hA5);
        // Left shift of 0x81 by 3
        row(0, 0, 0, 0, 0, 0, 0, 8'h81, 1, 8'h81, 0, 0, 8'h81);
        row(0, 1, 1, 0, 0, 3, 0, 8'h00, 1, 8'h81, 1, 0, 8'h81);
        row(0, 1, 0, 0, 0, 0, 0, 8'h00, 1, 8'h02, 1, 0, 8'h02);
        row(0, 1, 0, 0, 0, 0, 0, 8'h00, 1, 8'h04, 1, 0, 8'h04);
        row(0, 1, 0, 0, 0, 0, 0, 8'h00, 1, 8'h08, 0, 1, 8'h08);
        row(0, 1, 0, 0, 0, 0, 0, 8'h00, 1, 8'h08, 0, 0, 8'h08);
        // Zero amount: done next cycle, no busy, no change
        row(0, 1, 1, 0, 0, 0, 0, 8'h00, 1, 8'h08, 0, 1, 8'h08);
        row(0, 1, 0, 0, 0, 0, 0, 8'h00, 1, 8'h08, 0, 0, 8'h08);
        // Amount 12 saturates to 8
        row(0, 0, 0, 0, 0, 0, 0, 8'hFF, 1, 8'hFF, 0, 0, 8'hFF);
        row(0, 1, 1, 0, 0, 12, 0, 8'h00, 1, 8'hFF, 1, 0, 8'hFF);
        for (int s = 1; s <= 8; s++) begin
            e = 8'hFF << s;
            row(0, 1, 0, 0, 0, 0, 0, 8'h00, 1, e, (s < 8), (s == 8), e);
        end
        // Load and Sh together: load wins
        row(0, 0, 1, 0, 0, 3, 0, 8'h55, 1, 8'h55, 0, 0, 8'h55);
        row(0, 1, 0, 0, 0, 0, 0, 8'h00, 1, 8'h55, 0, 0, 8'h55);
        // Right shift of reg1 with loads and Sh during busy
        row(0, 0, 0, 1, 0, 0, 0, 8'h0F, 1, 8'h55, 0, 0, 8'h0F);
        row(0, 1, 1, 1, 1, 4, 0, 8'h00, 1, 8'h55, 1, 0, 8'h0F);
        row(0, 0, 0, 1, 0, 0, 0, 8'hFF, 1, 8'h55, 1, 0, 8'h07);
        row(0, 0, 0, 3, 0, 0, 0, 8'h3C, 1, 8'h55, 1, 0, 8'h3C);
        row(0, 1, 1, 1, 0, 1, 0, 8'h00, 1, 8'h55, 1, 0, 8'h01);
        row(0, 1, 0, 1, 0, 0, 0, 8'h00, 1, 8'h55, 0, 1, 8'h00);
        row(0, 1, 0, 3, 0, 0, 0, 8'h00, 1, 8'h55, 0, 0, 8'h3C);
        row(0, 1, 0, 0, 0, 0, 0, 8'h00, 1, 8'h55, 0, 0, 8'h55);
        // Flags: 0x80 then right shift by 8
        row(0, 0, 0, 0, 0, 0, 0, 8'h80, 1, 8'h80, 0, 0, 8'h80);
        row(0, 1, 1, 0, 1, 8, 0, 8'h00, 1, 8'h80, 1, 0, 8'h80);
        for (int s = 1; s <= 8; s++) begin
            e = 8'h80 >> s;
            row(0, 1, 0, 0, 0, 0, 0, 8'h00, 1, e, (s < 8), (s == 8), e);
        end
        // Reset in the 2nd cycle of a 5-bit shift
        row(0, 0, 0, 0, 0, 0, 0, 8'h0F, 1, 8'h0F, 0, 0, 8'h0F);
        row(0, 1, 1, 0, 0, 5, 0, 8'h00, 1, 8'h0F, 1, 0, 8'h0F);
        row(0, 1, 0, 0, 0, 0, 0, 8'h00, 1, 8'h1E, 1, 0, 8'h1E);
        row(1, 1, 0, 3, 0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00);
        row(0, 1, 0, 1, 0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00);
        row(0, 1, 0, 2, 0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00);
`ifdef SAP_ACC_ROTATE_EN
        row(0, 0, 0, 0, 0, 0, 0, 8'h81, 1, 8'h81, 0, 0, 8'h81);
        row(0, 1, 1, 0, 0, 3, 1, 8'h00, 1, 8'h81, 1, 0, 8'h81);
        row(0, 1, 0, 0, 0, 0, 0, 8'h00, 1, 8'h03, 1, 0, 8'h03);
        row(0, 1, 0, 0, 0, 0, 0, 8'h00, 1, 8'h06, 1, 0, 8'h06);
        row(0, 1, 0, 0, 0, 0, 0, 8'h00, 1, 8'h0C, 0, 1, 8'h0C);
        row(0, 0, 0, 0, 0, 0, 0, 8'hFF, 1, 8'hFF, 0, 0, 8'hFF);
        row(0, 1, 1, 0, 1, 8, 1, 8'h00, 1, 8'hFF, 1, 0, 8'hFF);
        for (int s = 1; s <= 8; s++) begin
            row(0, 1, 0, 0, 0, 0, 0, 8'h00, 1, 8'hFF, (s < 8), (s == 8), 8'hFF);
        end
`endif

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].la_n, vecs[i].sh, vecs[i].sel, vecs[i].dir,
                  vecs[i].amt, vecs[i].rot, vecs[i].din, vecs[i].ea);
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].e_acc, vecs[i].e_busy,
                       vecs[i].e_done, vecs[i].ea, vecs[i].e_dout);
        end

        // Bus release: with Ea low the loaded value must not appear on data_out
        drive(0, 0, 0, 2, 0, 0, 0, 8'hA5, 0);
        tick();
        n_total++;
        if (data_out !== 8'hA5) n_pass++;
        else $display("FAIL bus_release: got %02h, expected not driven", data_out);
        drive(0, 1, 0, 2, 0, 0, 0, 8'h00, 1);
        #1;
        chk("bus_drive", data_out, 8'hA5);

        // Back-to-back: a new Sh accepted on the cycle done is high
        drive(0, 0, 0, 0, 0, 0, 0, 8'h01, 0);
        tick();
        drive(0, 1, 1, 0, 0, 2, 0, 8'h00, 0);
        tick();
        check_outs("b2b start", 8'h01, 1, 0, 0, 8'h00);
        drive(0, 1, 0, 0, 0, 0, 0, 8'h00, 0);
        tick();
        check_outs("b2b step1", 8'h02, 1, 0, 0, 8'h00);
        tick();
        check_outs("b2b end1", 8'h04, 0, 1, 0, 8'h00);
        drive(0, 1, 1, 0, 0, 1, 0, 8'h00, 0);
        tick();
        check_outs("b2b restart", 8'h04, 1, 0, 0, 8'h00);
        drive(0, 1, 0, 0, 0, 0, 0, 8'h00, 0);
        tick();
        check_outs("b2b end2", 8'h08, 0, 1, 0, 8'h00);

        // Randomized traffic against the model
        drive(1, 1, 0, 0, 0, 0, 0, 8'h00, 0);
        @(posedge CLK);
        model_step();
        #1;
        for (int c = 0; c < 800; c++) begin
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  ROT_EN & 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
            @(posedge CLK);
            model_step();
            #1;
            check_outs($sformatf("rnd%0d", c), m_regs[0], m_busy, m_done, Ea, m_regs[sel]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/accumulator_bank.md
# accumulator_bank

Parametrised successor to the SAP-1 single accumulator. It holds NREG registers of WIDTH bits that are loaded from the W bus and driven back onto it through a tri-state output. Register 0 is the accumulator that feeds the adder/subtractor. A multi-cycle serial shift engine with a busy/done handshake adds shift operations to any register, and zero/negative flags on register 0 support conditional control.

## Interface
- WIDTH, 8: data width in bits; must be at least 2.
- NREG, 4: number of registers; a power of two, at least 2.
- SEL_W, $clog2(NREG): localparam, width of the register select.
- AMT_W, $clog2(WIDTH)+1: localparam, width of the shift amount.
- CLK  in  1  clock; all state changes on rising edge.
- CLR  in  1  reset, synchronous, active-high.
- La_bar  in  1  active-low load of register sel from data_in.
- Ea  in  1  output enable; drives register sel onto data_out, else Z.
- sel  in  SEL_W  register select for load, output and shift start.
- Sh  in  1  shift start, sampled at the edge.
- dir  in  1  shift direction: 0 = left (toward MSB), 1 = right.
- shamt  in  AMT_W  shift amount; values above WIDTH saturate to WIDTH.
- rot  in  1  rotate instead of shift. Present only with SAP_ACC_ROTATE_EN.
- data_in  in  WIDTH  W bus input.
- data_out  out  WIDTH  tri-state W bus output.
- adder_sub_out  out  WIDTH  register 0; always driven.
- busy  out  1  shift engine is active.
- done  out  1  one-cycle pulse when a shift completes.
- zero  out  1  register 0 equals 0; combinational.
- neg  out  1  MSB of register 0; combinational.

## Operation
- **State machine.** Two states, IDLE and SHIFT. Internal registers: tsel, tdir, trot and count.
- **Load.**
  - In IDLE, La_bar=0 loads data_in into register sel at the edge.
  - In SHIFT, a load to any register other than tsel is performed.
  - In SHIFT, a load to tsel is ignored.
- **Shift start.**
  - Conditions: IDLE, Sh=1 and La_bar=1. When La_bar=0 and Sh=1 together, the load wins and Sh is dropped.
  - If the saturated shamt is 0: no state change, and done=1 for the next cycle.
  - Otherwise: latch tsel=sel, tdir=dir, trot=rot (0 when rot is absent) and count=saturated shamt; go to SHIFT.
  - Sh in SHIFT is ignored and not queued.
- **SHIFT step.** Each edge moves register tsel by one bit; the vacated bit is 0, or the wrapped bit when trot=1. count decrements. When count reaches 1, the step completes and the block returns to IDLE with done=1 for one cycle.
- **Bus output.**
  - data_out = Ea ? reg[sel] : 'z, combinational.
  - In SHIFT, data_out shows the intermediate value.
- **Reset.** CLR=1 at the edge clears all registers, count, busy and done, and forces IDLE. CLR overrides La_bar and Sh. A shift in progress is abandoned with no done pulse.
- **Reset outputs.** adder_sub_out=0, zero=1, neg=0, busy=0, done=0; data_out=Z when Ea=0.

## Timing
- Load latency: one edge. The new value is visible on data_out and adder_sub_out immediately after the edge.
- Shift of k, 1 ≤ k ≤ WIDTH, started at edge N:
  - busy=1 after edge N.
  - Edges N+1 through N+k each shift one bit.
  - After edge N+k: busy=0, done=1 for exactly one cycle.
- A new Sh is accepted on the edge where done=1 (the state is IDLE by then), so back-to-back shifts are possible.
- A shift of WIDTH without rotate clears the register; with rotate, the register is unchanged.
- zero and neg follow register 0 combinationally, including during shifts.

## Configuration
- SAP_ACC_ROTATE_EN defined:
  - The rot port exists.
  - rot=1 at start selects a rotate: the bit leaving one end enters the other.
- SAP_ACC_ROTATE_EN undefined:
  - The rot port is absent, trot is tied to 0, and all shifts zero-fill.
  - The rotate logic is not synthesised.

## Structure
- Package sap_acc_pkg:
  - typedef enum logic {IDLE, SHIFT} acc_state_t;
  - direction constants DIR_LEFT=1'b0 and DIR_RIGHT=1'b1.
- Sub-module acc_shift_step: combinational one-bit shift/rotate of WIDTH bits, with inputs dir and rot. It is instantiated once on the tsel register path.
- The register array, the FSM and the tri-state driver stay in accumulator_bank.

## Test plan
All scenarios use WIDTH=8 and NREG=4.
- **Reset/load/read.** CLR pulse gives adder_sub_out=0, zero=1. Load reg2=8'hA5, then Ea=1 with sel=2 gives data_out=8'hA5. Ea=0 gives data_out=Z.
- **Left shift.** reg0=8'h81, Sh with dir=0, shamt=3 gives busy for 3 cycles, then reg0=8'h08 and a done pulse one cycle wide. Rotate build with rot=1 gives 8'h0C.
- **Boundaries.**
  - shamt=0 gives done the next cycle with no busy and no change.
  - shamt=12 saturates to 8, and reg0=8'hFF becomes 8'h00.
  - Rotate by 8 leaves 8'hFF unchanged.
- **Collisions.**
  - La_bar=0 with Sh=1 in IDLE loads and starts no shift.
  - During a shift of reg1, a load to reg1 is ignored and a load of 8'h3C to reg3 succeeds.
  - Sh during busy is ignored.
- **Reset mid-shift.** CLR at the 2nd cycle of a 5-bit shift gives all registers 0, busy=0 and no done pulse.
- **Flags.** Load reg0=8'h80 gives neg=1, zero=0. A right shift by 8 gives zero=1, neg=0.
